// File: rtl/t03_dpu_reg_bridge.sv
// -----------------------------------------------------------------------------
// t03_dpu_reg_bridge
//
// Bridges CPU register writes into the display pipeline. The CPU writes a
// shadow bank at any time. A COMMIT write arms a transfer. The next
// frame_sync (start of vertical blanking) copies the whole shadow bank into the
// active bank in one edge. The display therefore never sees a half-updated
// frame.
//
// Register map (address[31:8] must be 24'hFF0000, offset = address[7:0]):
//   0x00 GAME   data[2:0]  -> gameState
//   0x01 P1     data[1:0] state, data[5:2] health, data[6] left
//   0x02 P2     same layout as P1, for player 2
//   0x03 P1POS  data[10:0] -> x1, data[26:16] -> y1
//   0x04 P2POS  data[10:0] -> x2, data[26:16] -> y2
//   0x05 COMMIT data ignored
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wen/address/data  CPU write port, one write per cycle
//   frame_sync        one-cycle vertical-blanking strobe
//   ack               one-cycle acknowledge, the cycle after an in-range write
//   err               pulses with ack when the in-range offset is unmapped
//   pending           commit armed, waiting for frame_sync
//   gameState .. p2Left  active display registers
// -----------------------------------------------------------------------------
module t03_dpu_reg_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        frame_sync,
  output logic        ack,
  output logic        err,
  output logic        pending,
  output logic [2:0]  gameState,
  output logic [1:0]  p1State,
  output logic [1:0]  p2State,
  output logic [3:0]  p1health,
  output logic [3:0]  p2health,
  output logic [10:0] x1,
  output logic [10:0] x2,
  output logic [10:0] y1,
  output logic [10:0] y2,
  output logic        p1Left,
  output logic        p2Left
);

  typedef struct packed {
    logic [2:0]  game_state;
    logic [1:0]  p1_state;
    logic [3:0]  p1_health;
    logic        p1_left;
    logic [1:0]  p2_state;
    logic [3:0]  p2_health;
    logic        p2_left;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
  } bank_t;

  localparam bank_t RESET_BANK = '{
    game_state: 3'd0,
    p1_state:   2'd0,
    p1_health:  4'd9,
    p1_left:    1'b0,
    p2_state:   2'd0,
    p2_health:  4'd9,
    p2_left:    1'b1,
    x1:         11'd100,
    y1:         11'd0,
    x2:         11'd500,
    y2:         11'd0
  };

  localparam logic [23:0] BASE_PAGE  = 24'hFF0000;
  localparam logic [7:0]  OFS_GAME   = 8'h00;
  localparam logic [7:0]  OFS_P1     = 8'h01;
  localparam logic [7:0]  OFS_P2     = 8'h02;
  localparam logic [7:0]  OFS_P1POS  = 8'h03;
  localparam logic [7:0]  OFS_P2POS  = 8'h04;
  localparam logic [7:0]  OFS_COMMIT = 8'h05;

  localparam logic [3:0]  HEALTH_MAX = 4'd9;
  localparam logic [10:0] X_MAX      = 11'd639;
  localparam logic [10:0] Y_MAX      = 11'd500;

  // Saturate out-of-screen / out-of-range values when they enter the shadow bank.
  function automatic logic [3:0] clamp_health(input logic [3:0] h);
    return (h > HEALTH_MAX) ? HEALTH_MAX : h;
  endfunction

  function automatic logic [10:0] clamp_x(input logic [10:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [10:0] clamp_y(input logic [10:0] y);
    return (y > Y_MAX) ? Y_MAX : y;
  endfunction

  bank_t       shadow;
  bank_t       shadow_nxt;
  bank_t       active;
  logic [7:0]  offset;
  logic        in_range;
  logic        mapped;
  logic        commit_wr;
  logic        transfer;

  // These data bits have no meaning in any register and are dropped.
  logic        unused_data_bits;
  assign unused_data_bits = &{1'b0, data[31:27], data[15:11]};

  assign offset    = address[7:0];
  assign in_range  = wen && (address[31:8] == BASE_PAGE);
  assign mapped    = (offset <= OFS_COMMIT);
  assign commit_wr = in_range && (offset == OFS_COMMIT);
  assign transfer  = frame_sync && pending;

  // Shadow write decode. Unmapped offsets and COMMIT leave the bank as it is.
  always_comb begin
    // NOTE: the default assignment first keeps every field driven on every
    // path, so no latch is inferred for offsets the case does not list.
    shadow_nxt = shadow;
    if (in_range) begin
      case (offset)
        OFS_GAME: shadow_nxt.game_state = data[2:0];
        OFS_P1: begin
          shadow_nxt.p1_state  = data[1:0];
          shadow_nxt.p1_health = clamp_health(data[5:2]);
          shadow_nxt.p1_left   = data[6];
        end
        OFS_P2: begin
          shadow_nxt.p2_state  = data[1:0];
          shadow_nxt.p2_health = clamp_health(data[5:2]);
          shadow_nxt.p2_left   = data[6];
        end
        OFS_P1POS: begin
          shadow_nxt.x1 = clamp_x(data[10:0]);
          shadow_nxt.y1 = clamp_y(data[26:16]);
        end
        OFS_P2POS: begin
          shadow_nxt.x2 = clamp_x(data[10:0]);
          shadow_nxt.y2 = clamp_y(data[26:16]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both banks are plain flop registers rather than RAM, so they are
      // reset explicitly; the display must show defined values straight away.
      shadow  <= RESET_BANK;
      active  <= RESET_BANK;
      pending <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the transfer read the shadow value
      // from before this edge, so a write landing on the same edge waits in
      // shadow for the next commit.
      shadow <= shadow_nxt;
      if (transfer) begin
        active <= shadow;
      end
      ack <= in_range;
      err <= in_range && !mapped;
      // A COMMIT on the transfer edge re-arms for the following frame.
      if (commit_wr) begin
        pending <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
    end
  end

  assign gameState = active.game_state;
  assign p1State   = active.p1_state;
  assign p2State   = active.p2_state;
  assign p1health  = active.p1_health;
  assign p2health  = active.p2_health;
  assign p1Left    = active.p1_left;
  assign p2Left    = active.p2_left;
  assign x1        = active.x1;
  assign y1        = active.y1;
  assign x2        = active.x2;
  assign y2        = active.y2;

endmodule

// File: tb/tb_t03_dpu_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_t03_dpu_reg_bridge
//
// Directed bench for t03_dpu_reg_bridge. Each task drives one scenario and
// compares the DUT outputs against hand-computed expected values. Inputs
// change on the falling edge. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_t03_dpu_reg_bridge;

  typedef struct packed {
    logic [2:0]  gs;
    logic [1:0]  p1s;
    logic [3:0]  p1h;
    logic        p1l;
    logic [1:0]  p2s;
    logic [3:0]  p2h;
    logic        p2l;
    logic [10:0] x1;
    logic [10:0] y1;
    logic [10:0] x2;
    logic [10:0] y2;
  } disp_t;

  localparam disp_t RST_D = {3'd0, 2'd0, 4'd9, 1'b0, 2'd0, 4'd9, 1'b1,
                             11'd100, 11'd0, 11'd500, 11'd0};

  localparam logic [31:0] A_GAME   = 32'hFF00_0000;
  localparam logic [31:0] A_P1     = 32'hFF00_0001;
  localparam logic [31:0] A_P2     = 32'hFF00_0002;
  localparam logic [31:0] A_P1POS  = 32'hFF00_0003;
  localparam logic [31:0] A_P2POS  = 32'hFF00_0004;
  localparam logic [31:0] A_COMMIT = 32'hFF00_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen;
  logic [31:0] address;
  logic [31:0] data;
  logic        frame_sync;
  logic        ack;
  logic        err;
  logic        pending;
  logic [2:0]  gameState;
  logic [1:0]  p1State;
  logic [1:0]  p2State;
  logic [3:0]  p1health;
  logic [3:0]  p2health;
  logic [10:0] x1;
  logic [10:0] x2;
  logic [10:0] y1;
  logic [10:0] y2;
  logic        p1Left;
  logic        p2Left;

  int    total = 0;
  int    bad   = 0;
  disp_t exp_d;

  always #50 clk = ~clk;

  t03_dpu_reg_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .address    (address),
    .data       (data),
    .frame_sync (frame_sync),
    .ack        (ack),
    .err        (err),
    .pending    (pending),
    .gameState  (gameState),
    .p1State    (p1State),
    .p2State    (p2State),
    .p1health   (p1health),
    .p2health   (p2health),
    .x1         (x1),
    .x2         (x2),
    .y1         (y1),
    .y2         (y2),
    .p1Left     (p1Left),
    .p2Left     (p2Left)
  );

  function automatic disp_t observed();
    return {gameState, p1State, p1health, p1Left, p2State, p2health, p2Left,
            x1, y1, x2, y2};
  endfunction

  function automatic logic [2:0] flags();
    return {ack, err, pending};
  endfunction

  // One clock of stimulus; returns 1 ns after the rising edge.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic fs);
    @(negedge clk);
    wen        = w;
    address    = a;
    data       = d;
    frame_sync = fs;
    @(posedge clk);
    #1;
    wen        = 1'b0;
    address    = 32'h0;
    data       = 32'h0;
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    exp_d = RST_D;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL reset_disp: got %h want %h", observed(), exp_d);
    end
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got %b want %b", flags(), 3'b000);
    end
  endtask

  task automatic test_pos_commit();
    drive(1'b1, A_P1POS, 32'h00C8_0140, 1'b0);
    total++;
    if (flags() !== 3'b100) begin
      bad++;
      $display("FAIL pos_write_ack: got %b want %b", flags(), 3'b100);
    end
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL pos_before_commit: got %h want %h", observed(), exp_d);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL ack_one_cycle: got %b want %b", flags(), 3'b000);
    end
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    total++;
    if (flags() !== 3'b101) begin
      bad++;
      $display("FAIL commit_ack_pending: got %b want %b", flags(), 3'b101);
    end
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL pos_before_sync: got %h want %h", observed(), exp_d);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.x1 = 11'd320;
    exp_d.y1 = 11'd200;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL pos_after_sync: got %h want %h", observed(), exp_d);
    end
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL pending_cleared: got %b want %b", flags(), 3'b000);
    end
  endtask

  task automatic test_players();
    // P1 0x7F: state 3, health 15 -> 9, left 1. P2 0x1E: state 2, health 7, left 0.
    drive(1'b1, A_P1, 32'h0000_007F, 1'b0);
    drive(1'b1, A_P2, 32'h0000_001E, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.p1s = 2'd3; exp_d.p1h = 4'd9; exp_d.p1l = 1'b1;
    exp_d.p2s = 2'd2; exp_d.p2h = 4'd7; exp_d.p2l = 1'b0;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL player_fields: got %h want %h", observed(), exp_d);
    end
    // Health boundary: 8 stays 8, 10 saturates to 9.
    drive(1'b1, A_P1, 32'h0000_0020, 1'b0);
    drive(1'b1, A_P2, 32'h0000_0028, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.p1s = 2'd0; exp_d.p1h = 4'd8; exp_d.p1l = 1'b0;
    exp_d.p2s = 2'd0; exp_d.p2h = 4'd9; exp_d.p2l = 1'b0;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL health_boundary: got %h want %h", observed(), exp_d);
    end
  endtask

  task automatic test_pos_clamp();
    // x2 2047 -> 639, y2 1000 -> 500; x1 639 and y1 500 sit exactly at the limit.
    drive(1'b1, A_P2POS, 32'h03E8_07FF, 1'b0);
    drive(1'b1, A_P1POS, 32'h01F4_027F, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.x2 = 11'd639; exp_d.y2 = 11'd500;
    exp_d.x1 = 11'd639; exp_d.y1 = 11'd500;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL pos_clamp: got %h want %h", observed(), exp_d);
    end
    // Unused bits set: x1 = 50, y1 = 100, gameState = 1.
    drive(1'b1, A_P1POS, 32'hF864_F832, 1'b0);
    drive(1'b1, A_GAME, 32'hFFFF_FFF9, 1'b0);
    drive(1'b1, A_COMMIT, 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.x1 = 11'd50; exp_d.y1 = 11'd100; exp_d.gs = 3'd1;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL unused_bits: got %h want %h", observed(), exp_d);
    end
  endtask

  task automatic test_unmapped();
    drive(1'b1, 32'hFF00_0007, 32'hFFFF_FFFF, 1'b0);
    total++;
    if (flags() !== 3'b110) begin
      bad++;
      $display("FAIL unmapped_err: got %b want %b", flags(), 3'b110);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL err_one_cycle: got %b want %b", flags(), 3'b000);
    end
    drive(1'b1, 32'h1200_0001, 32'h0000_007F, 1'b0);
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL out_of_range_ack: got %b want %b", flags(), 3'b000);
    end
    // In-range COMMIT address with wen low is not a write.
    drive(1'b0, A_COMMIT, 32'h0, 1'b0);
    total++;
    if (flags() !== 3'b000) begin
      bad++;
      $display("FAIL no_wen_commit: got %b want %b", flags(), 3'b000);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL idle_sync: got %h want %h", observed(), exp_d);
    end
    // Commit whatever shadow holds: nothing above may have changed it.
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL unmapped_no_change: got %h want %h", observed(), exp_d);
    end
  endtask

  task automatic test_coincident();
    drive(1'b1, A_GAME, 32'd2, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b1, A_GAME, 32'd5, 1'b1);
    exp_d.gs = 3'd2;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL write_during_xfer: got %h want %h", observed(), exp_d);
    end
    total++;
    if (flags() !== 3'b100) begin
      bad++;
      $display("FAIL write_during_xfer_flags: got %b want %b", flags(), 3'b100);
    end
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.gs = 3'd5;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL held_write_commit: got %h want %h", observed(), exp_d);
    end
  endtask

  task automatic test_commit_sync();
    // COMMIT with frame_sync while idle: arm only.
    drive(1'b1, A_GAME, 32'd6, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL commit_sync_idle: got %h want %h", observed(), exp_d);
    end
    total++;
    if (flags() !== 3'b101) begin
      bad++;
      $display("FAIL commit_sync_idle_flags: got %b want %b", flags(), 3'b101);
    end
    // COMMIT with frame_sync while armed: transfer and stay armed.
    drive(1'b1, A_GAME, 32'd7, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b1);
    exp_d.gs = 3'd7;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL commit_sync_armed: got %h want %h", observed(), exp_d);
    end
    total++;
    if (flags() !== 3'b101) begin
      bad++;
      $display("FAIL rearmed_flags: got %b want %b", flags(), 3'b101);
    end
    drive(1'b1, A_GAME, 32'd3, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.gs = 3'd3;
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL rearmed_xfer: got %h want %h", observed(), exp_d);
    end
    // frame_sync while not armed does nothing.
    drive(1'b1, A_GAME, 32'd4, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL sync_not_armed: got %h want %h", observed(), exp_d);
    end
    // Two COMMITs collapse into one transfer.
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    exp_d.gs = 3'd4;
    total++;
    if (observed() !== exp_d || flags() !== 3'b000) begin
      bad++;
      $display("FAIL double_commit: got %h/%b want %h/%b", observed(), flags(),
               exp_d, 3'b000);
    end
  endtask

  task automatic test_reset_discard();
    drive(1'b1, A_P2, 32'h0000_007F, 1'b0);
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    total++;
    if (pending !== 1'b1) begin
      bad++;
      $display("FAIL armed_before_rst: got %b want %b", pending, 1'b1);
    end
    // Reset wins over a simultaneous COMMIT write and frame_sync.
    rst = 1'b1;
    drive(1'b1, A_COMMIT, 32'h0, 1'b1);
    rst = 1'b0;
    exp_d = RST_D;
    total++;
    if (observed() !== exp_d || flags() !== 3'b000) begin
      bad++;
      $display("FAIL rst_priority: got %h/%b want %h/%b", observed(), flags(),
               exp_d, 3'b000);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL sync_after_rst: got %h want %h", observed(), exp_d);
    end
    // Shadow was reset too, so a fresh commit still shows reset values.
    drive(1'b1, A_COMMIT, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    total++;
    if (observed() !== exp_d) begin
      bad++;
      $display("FAIL shadow_rst: got %h want %h", observed(), exp_d);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wen        = 1'b0;
    address    = 32'h0;
    data       = 32'h0;
    frame_sync = 1'b0;
    test_reset();
    test_pos_commit();
    test_players();
    test_pos_clamp();
    test_unmapped();
    test_coincident();
    test_commit_sync();
    test_reset_discard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t03_dpu_reg_bridge.md
T03_DPU_REG_BRIDGE -- requirements
Module: t03_dpu_reg_bridge

Interface
REQ-001 SHALL have port: clk  input  1  system clock (10 MHz display clock).
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: wen  input  1  CPU write strobe, one write per cycle high.
REQ-004 SHALL have port: address  input  32  CPU word address.
REQ-005 SHALL have port: data  input  32  CPU write data.
REQ-006 SHALL have port: frame_sync  input  1  one-cycle strobe at start of vertical blanking.
REQ-007 SHALL have port: ack  output  1  write acknowledge.
REQ-008 SHALL have port: err  output  1  unmapped-write indication.
REQ-009 SHALL have port: pending  output  1  commit armed, awaiting frame_sync.
REQ-010 SHALL have ports: gameState  output  3; p1State, p2State  output  2; p1health, p2health  output  4; x1, x2, y1, y2  output  11; p1Left, p2Left  output  1; these are the active display registers that feed the display top.

Function
REQ-011 SHALL hold two register banks: shadow (CPU-written) and active (drives outputs); outputs SHALL change only on a commit transfer or reset.
REQ-012 SHALL decode a write as in-range when wen=1 and address[31:8]=24'hFF0000; offset = address[7:0].
REQ-013 SHALL map offsets: 0x00 GAME data[2:0]->gameState; 0x01 P1 data[1:0]->state, data[5:2]->health, data[6]->left; 0x02 P2 same layout for player 2; 0x03 P1POS data[10:0]->x1, data[26:16]->y1; 0x04 P2POS same for x2/y2; 0x05 COMMIT (data ignored).
REQ-014 SHALL clamp on shadow write: health >9 stored as 9; x >639 stored as 639; y >500 stored as 500.
REQ-015 SHALL ignore unused data bits.
REQ-016 SHALL assert ack for exactly one cycle, the cycle after any in-range write (mapped or not); no ack for out-of-range writes.
REQ-017 SHALL assert err for one cycle, coincident with ack, when an in-range offset >0x05; no register changes.
REQ-018 SHALL set pending on the cycle after a COMMIT write.
REQ-019 SHALL, on frame_sync=1 with pending=1, copy all shadow fields into active on that clock edge and clear pending; outputs reflect shadow on the next cycle.
REQ-020 SHALL ignore frame_sync when pending=0; active bank unchanged.
REQ-021 SHALL, for a shadow write in the same cycle as a transfer, copy the pre-write shadow value to active; the new value stays in shadow until the next commit.
REQ-022 SHALL, for a COMMIT write in the same cycle as frame_sync with pending=1, perform the transfer and leave pending=1 (re-armed for the next frame).
REQ-023 SHALL, for a COMMIT write in the same cycle as frame_sync with pending=0, perform no transfer and set pending=1.
REQ-024 SHALL treat repeated COMMIT writes while pending as a single commit.
REQ-025 SHALL make shadow writes with no COMMIT invisible at the outputs indefinitely.

Reset
REQ-026 SHALL on rst=1 set both banks to: gameState=0, p1State=p2State=0, p1health=p2health=9, x1=100, x2=500, y1=y2=0, p1Left=0, p2Left=1; pending=0, ack=0, err=0.
REQ-027 SHALL give rst priority over wen and frame_sync in the same cycle; a commit armed before reset SHALL be discarded.

Verification
REQ-028 SHALL cover: write 0xFF000003 data=0x00C8_0140, then COMMIT, then frame_sync -> ack one cycle after each write; x1=320, y1=200 the cycle after frame_sync; unchanged before it.
REQ-029 SHALL cover: write P1 data=0x7F, COMMIT, frame_sync -> p1State=3, p1health=9 (clamped from 15), p1Left=1.
REQ-030 SHALL cover: write 0xFF000004 data=0x03E8_07FF with COMMIT -> x2=639, y2=500 after transfer.
REQ-031 SHALL cover: write 0xFF000007 -> ack=1 and err=1 one cycle; write 0x12000001 -> ack=0; all outputs unchanged.
REQ-032 SHALL cover: pending=1, GAME write data=5 coincident with frame_sync -> active gameState = prior shadow value; a later COMMIT plus frame_sync yields gameState=5.
REQ-033 SHALL cover: COMMIT armed then rst before frame_sync -> pending=0, outputs at reset values; a subsequent frame_sync makes no change.
